// File: rtl/conv1_line_buf_if.sv
// conv1_line_buf_if
// Bundles the pixel stream into the window generator and the 3x3 window it
// presents to the conv1 calculation stage.
//   valid_in / pixel_in        : one raster-order pixel, accepted when valid_in=1
//   pixel_0 .. pixel_8         : window, row-major, pixel_0 = top-left (r-2,c-2),
//                                pixel_8 = bottom-right (r,c)
//   valid_out_buf              : window valid this cycle (single-cycle strobe)
//   frame_done                 : only with CONV1_BUF_FRAME_DONE_EN; pulses with
//                                the last window of a frame
// Handshake: no backpressure. A pixel is consumed on every rising clk edge
// where valid_in=1. A window is valid only in the cycle valid_out_buf=1 and
// must be consumed in that cycle.
// Modports: slave = the window generator, master = the pixel source / window sink.
interface conv1_line_buf_if #(
  parameter int DATA_W = 8
);
  logic              valid_in;
  logic [DATA_W-1:0] pixel_in;
  logic [DATA_W-1:0] pixel_0;
  logic [DATA_W-1:0] pixel_1;
  logic [DATA_W-1:0] pixel_2;
  logic [DATA_W-1:0] pixel_3;
  logic [DATA_W-1:0] pixel_4;
  logic [DATA_W-1:0] pixel_5;
  logic [DATA_W-1:0] pixel_6;
  logic [DATA_W-1:0] pixel_7;
  logic [DATA_W-1:0] pixel_8;
  logic              valid_out_buf;
`ifdef CONV1_BUF_FRAME_DONE_EN
  logic              frame_done;
`endif

  modport slave (
    input  valid_in, pixel_in,
    output pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
           pixel_5, pixel_6, pixel_7, pixel_8, valid_out_buf
`ifdef CONV1_BUF_FRAME_DONE_EN
    , output frame_done
`endif
  );

  modport master (
    output valid_in, pixel_in,
    input  pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
           pixel_5, pixel_6, pixel_7, pixel_8, valid_out_buf
`ifdef CONV1_BUF_FRAME_DONE_EN
    , input frame_done
`endif
  );
endinterface

// File: rtl/conv1_line_buf.sv
// conv1_line_buf
// Streaming 3x3 window generator for the first binary-convolution layer.
// Accepts raster-order pixels, keeps the two previous rows in shift-register
// line buffers and presents a registered 3x3 window one cycle after each
// accepted pixel (r,c) with r>=2 and c>=2.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : conv1_line_buf_if.slave (pixel stream in, window out)
// Optional feature macro: CONV1_BUF_FRAME_DONE_EN adds bus.frame_done, a pulse
// coincident with the valid strobe of the last window of each frame.
module conv1_line_buf #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  conv1_line_buf_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // Line buffers: index 0 receives the newest pixel, index IMG_W-1 is the tap
  // holding the pixel exactly one row earlier.
  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb0_d [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] lb1_d [IMG_W];

  // Window, row-major: [0..2] row r-2, [3..5] row r-1, [6..8] row r.
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
`ifdef CONV1_BUF_FRAME_DONE_EN
  logic          frame_done_q, frame_done_d;
`endif

  always_comb begin
    lb0_d   = lb0_q;
    lb1_d   = lb1_q;
    win_d   = win_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
`ifdef CONV1_BUF_FRAME_DONE_EN
    frame_done_d = 1'b0;
`endif
    if (bus.valid_in) begin
      lb0_d[0] = bus.pixel_in;
      lb1_d[0] = lb0_q[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        lb0_d[i] = lb0_q[i-1];
        lb1_d[i] = lb1_q[i-1];
      end

      // Shift the window left; the new right column is (r-2,c),(r-1,c),(r,c).
      for (int k = 0; k < 3; k++) begin
        win_d[3*k]   = win_q[3*k+1];
        win_d[3*k+1] = win_q[3*k+2];
      end
      win_d[2] = lb1_q[IMG_W-1];
      win_d[5] = lb0_q[IMG_W-1];
      win_d[8] = bus.pixel_in;

      // Rows 0..1 and columns 0..1 produce windows that straddle the frame
      // or row edge; they are shifted but never flagged.
      valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
`ifdef CONV1_BUF_FRAME_DONE_EN
      frame_done_d = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
`endif

      if (col_q == CW'(IMG_W-1)) begin
        col_d = '0;
        if (row_q == RW'(IMG_H-1)) row_d = '0;
        else                       row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Line-buffer contents need no reset: stale data is never flagged valid
  // because the row counter gates the first two rows of every frame.
  always_ff @(posedge clk) begin
    lb0_q <= lb0_d;
    lb1_q <= lb1_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
`ifdef CONV1_BUF_FRAME_DONE_EN
      frame_done_q <= 1'b0;
`endif
    end else begin
      win_q   <= win_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
`ifdef CONV1_BUF_FRAME_DONE_EN
      frame_done_q <= frame_done_d;
`endif
    end
  end

  assign bus.pixel_0       = win_q[0];
  assign bus.pixel_1       = win_q[1];
  assign bus.pixel_2       = win_q[2];
  assign bus.pixel_3       = win_q[3];
  assign bus.pixel_4       = win_q[4];
  assign bus.pixel_5       = win_q[5];
  assign bus.pixel_6       = win_q[6];
  assign bus.pixel_7       = win_q[7];
  assign bus.pixel_8       = win_q[8];
  assign bus.valid_out_buf = valid_q;
`ifdef CONV1_BUF_FRAME_DONE_EN
  assign bus.frame_done    = frame_done_q;
`endif

endmodule

// File: tb/tb_conv1_line_buf.sv
// tb_conv1_line_buf
// Directed bench for conv1_line_buf. Every cycle the bench pushes the expected
// output of that cycle's input (valid, last-of-frame, window) into exp_q and, at
// the next falling edge, pops it and compares against the DUT.
module tb_conv1_line_buf;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int DATA_W = 8;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWIN   = (IMG_W - 2) * (IMG_H - 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv1_line_buf_if #(.DATA_W(DATA_W)) bus ();

  conv1_line_buf #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .DATA_W(DATA_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  // entry: [73] valid, [72] last window of frame, [71:0] window pixel_0..pixel_8
  logic [73:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int ndone  = 0;
  int r_m, c_m, off_m;

  function automatic logic [7:0] pix(input int off, input int r, input int c);
    return 8'((r * IMG_W + c + off) & 255);
  endfunction

  function automatic logic [71:0] win_obs();
    return {bus.pixel_0, bus.pixel_1, bus.pixel_2, bus.pixel_3, bus.pixel_4,
            bus.pixel_5, bus.pixel_6, bus.pixel_7, bus.pixel_8};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [73:0] e;
    if (exp_q.size() == 0) e = '0;
    else                   e = exp_q.pop_front();
    if (bus.valid_out_buf === 1'b1) nvalid++;
    chk("valid_out_buf", 72'(bus.valid_out_buf), 72'(e[73]));
    if (e[73]) chk("window", win_obs(), e[71:0]);
`ifdef CONV1_BUF_FRAME_DONE_EN
    if (bus.frame_done === 1'b1) ndone++;
    chk("frame_done", 72'(bus.frame_done), 72'(e[73] & e[72]));
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_window"}, win_obs(), 72'd0);
    chk({tag, "_valid"}, 72'(bus.valid_out_buf), 72'd0);
`ifdef CONV1_BUF_FRAME_DONE_EN
    chk({tag, "_frame_done"}, 72'(bus.frame_done), 72'd0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [7:0] p);
    logic [71:0] w;
    logic [73:0] e;
    @(negedge clk);
    check_outputs();
    bus.valid_in = v;
    bus.pixel_in = p;
    e = '0;
    if (v) begin
      if (r_m >= 2 && c_m >= 2) begin
        w = '0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            w = {w[63:0], pix(off_m, r_m - 2 + dr, c_m - 2 + dc)};
        e = {1'b1, (r_m == IMG_H - 1 && c_m == IMG_W - 1), w};
      end
      if (c_m == IMG_W - 1) begin
        c_m = 0;
        r_m = (r_m == IMG_H - 1) ? 0 : r_m + 1;
      end else begin
        c_m = c_m + 1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic run_pixels(input int off, input int max_idle, input int n);
    off_m = off;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, max_idle)) step(1'b0, 8'h00);
      step(1'b1, pix(off_m, r_m, c_m));
    end
  endtask

  // Reset is raised together with an accept to show reset wins.
  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rst_n        = 1'b0;
    bus.valid_in = 1'b1;
    bus.pixel_in = 8'hAA;
    #1;
    check_zero("rst_async");
    repeat (3) begin
      @(negedge clk);
      check_zero("rst_hold");
    end
    rst_n        = 1'b1;
    bus.valid_in = 1'b0;
    bus.pixel_in = 8'h00;
    exp_q.delete();
    r_m = 0;
    c_m = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.pixel_in = 8'h00;
    r_m = 0; c_m = 0; off_m = 0;
    do_reset();

    // single frame, continuous input
    nvalid = 0; ndone = 0;
    run_pixels(0, 0, NPIX);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("frame1_count", 72'(nvalid), 72'(NWIN));
    chk("last_pixel_0_hold", 72'(bus.pixel_0), 72'(8'd213));
    chk("last_pixel_8_hold", 72'(bus.pixel_8), 72'(8'd15));
`ifdef CONV1_BUF_FRAME_DONE_EN
    chk("frame1_done_count", 72'(ndone), 72'd1);
`endif

    // same frame with 0..3 random idle cycles between accepts
    nvalid = 0; ndone = 0;
    run_pixels(0, 3, NPIX);
    step(1'b0, 8'h00);
    chk("idle_frame_count", 72'(nvalid), 72'(NWIN));

    // two back-to-back frames, identical data, no gap
    nvalid = 0; ndone = 0;
    run_pixels(0, 0, 2 * NPIX);
    step(1'b0, 8'h00);
    chk("b2b_count", 72'(nvalid), 72'(2 * NWIN));
`ifdef CONV1_BUF_FRAME_DONE_EN
    chk("b2b_done_count", 72'(ndone), 72'd2);
`endif

    // reset mid-frame after 400 accepts, then a fresh frame with new data
    run_pixels(9, 0, 400);
    do_reset();
    nvalid = 0; ndone = 0;
    run_pixels(5, 1, NPIX);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("post_reset_count", 72'(nvalid), 72'(NWIN));
`ifdef CONV1_BUF_FRAME_DONE_EN
    chk("post_reset_done_count", 72'(ndone), 72'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
